// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Request captured at acceptance and replayed at the commit edge.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  // A request errors when it is misaligned or addresses beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_width);
    return ((addr >> (addr_width + 2)) != 32'd0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write and synchronous read; the responder never asserts both together.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time and answers after
// LATENCY cycles (legal range 1..MAX_LATENCY) with read data and status.
//
// Handshake: a request transfers on a rising edge where dm_req && dm_gnt.
// dm_gnt depends only on responder state, never on dm_req. The response is a
// single-cycle dm_rvalid strobe; dm_rdata/dm_err are meaningful only with it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [BE_W-1:0]   dm_be,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output dmem_state_e       dbg_state
);

  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_e state_q;
  logic        ready_q;
  logic [3:0]  count_q;
  dmem_req_t   req_q;
  logic        rvalid_q;
  logic        err_q;
  logic        load_ok_q;

  dmem_req_t         live_req;
  dmem_req_t         commit_req;
  logic              accept;
  logic              commit;
  logic              commit_err;
  logic              arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  assign live_req = '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
  assign dm_gnt   = ready_q && (state_q == IDLE);
  assign accept   = dm_req && dm_gnt;

  // Commit happens on the edge entering RESP. With single-cycle latency that
  // edge is the acceptance edge itself, so the live inputs are used directly.
  assign commit     = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                      ((state_q == BUSY) && (count_q == 4'd0));
  assign commit_req = (state_q == IDLE) ? live_req : req_q;
  // Error is derived from the captured address, identical to evaluating it at acceptance.
  assign commit_err = addr_err(commit_req.addr, ADDR_WIDTH);
  assign arr_we     = commit && commit_req.we && !commit_err;
  assign arr_re     = commit && !commit_req.we && !commit_err;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .be    (commit_req.be),
    .addr  (commit_req.addr[ADDR_WIDTH+1:2]),
    .wdata (commit_req.wdata),
    .rdata (arr_rdata)
  );

  // Control FSM, wait-state counter and registered response status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      count_q   <= 4'd0;
      req_q     <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
    end else begin
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q <= live_req;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              count_q <= CNT_INIT;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (count_q == 4'd0) state_q <= RESP;
          else                 count_q <= count_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        rvalid_q  <= 1'b1;
        err_q     <= commit_err;
        load_ok_q <= !commit_req.we && !commit_err;
      end
    end
  end

  // Read data is forced to zero unless the last response was a clean load.
  assign dm_rdata  = load_ok_q ? arr_rdata : '0;
  assign dm_rvalid = rvalid_q;
  assign dm_err    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 1, 4 and 3.
module tb_dmem_responder;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];
  dmem_state_e dbg    [3];

  dmem_responder #(.ADDR_WIDTH(14), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_n[0]), .dm_req(req[0]), .dm_we(we[0]), .dm_be(be[0]),
    .dm_addr(addr[0]), .dm_wdata(wdata[0]), .dm_gnt(gnt[0]), .dm_rvalid(rvalid[0]),
    .dm_rdata(rdata[0]), .dm_err(err[0]), .dbg_state(dbg[0]));

  dmem_responder #(.ADDR_WIDTH(14), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst_n[1]), .dm_req(req[1]), .dm_we(we[1]), .dm_be(be[1]),
    .dm_addr(addr[1]), .dm_wdata(wdata[1]), .dm_gnt(gnt[1]), .dm_rvalid(rvalid[1]),
    .dm_rdata(rdata[1]), .dm_err(err[1]), .dbg_state(dbg[1]));

  dmem_responder #(.ADDR_WIDTH(14), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst_n[2]), .dm_req(req[2]), .dm_we(we[2]), .dm_be(be[2]),
    .dm_addr(addr[2]), .dm_wdata(wdata[2]), .dm_gnt(gnt[2]), .dm_rvalid(rvalid[2]),
    .dm_rdata(rdata[2]), .dm_err(err[2]), .dbg_state(dbg[2]));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Issues one request on instance i, waits for acceptance and the response.
  // lat counts edges from acceptance to the edge that raises dm_rvalid, inclusive.
  task automatic txn(input int i, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    n = 0;
    while (gnt[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("gnt_timeout", {31'd0, gnt[i]}, 32'd1);
    @(negedge clk);
    req[i] = 1'b0;
    lat = 1;
    while (rvalid[i] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata[i];
    e  = err[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;
    logic        flag;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b1; we[i] = 1'b0; be[i] = 4'h0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_gnt",    {31'd0, gnt[0]},    32'd0);
    check("rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
    check("rst_rdata",  rdata[0],           32'd0);
    check("rst_err",    {31'd0, err[0]},    32'd0);
    check("rst_state",  32'(dbg[0]),        32'(IDLE));

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0;
      rst_n[i] = 1'b1;
    end
    #1;
    check("gnt_first_cycle", {31'd0, gnt[0]}, 32'd0);
    @(negedge clk);
    check("gnt_second_cycle", {31'd0, gnt[0]}, 32'd1);

    // LATENCY=1: store, then load back
    txn(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, rd, e, lat);
    check("st_lat",   32'(lat), 32'd1);
    check("st_err",   {31'd0, e}, 32'd0);
    check("st_rdata", rd, 32'd0);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, rvalid[0]}, 32'd0);
    txn(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, e, lat);
    check("ld_lat",   32'(lat), 32'd1);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err",   {31'd0, e}, 32'd0);

    // byte lanes; word 0 is also seeded for the error checks
    txn(0, 1'b1, 4'b0101, 32'h100, 32'h11223344, rd, e, lat);
    txn(0, 1'b1, 4'hF, 32'h0, 32'h12345678, rd, e, lat);
    txn(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, e, lat);
    check("lane_rdata", rd, 32'hDE22BE44);

    // errors
    txn(0, 1'b0, 4'hF, 32'h102, 32'h0, rd, e, lat);
    check("misal_ld_err",   {31'd0, e}, 32'd1);
    check("misal_ld_rdata", rd, 32'd0);
    txn(0, 1'b1, 4'hF, 32'h0004_0000, 32'hFFFFFFFF, rd, e, lat);
    check("oor_st_err", {31'd0, e}, 32'd1);
    txn(0, 1'b1, 4'hF, 32'h1, 32'hA5A5A5A5, rd, e, lat);
    check("misal_st_err", {31'd0, e}, 32'd1);
    txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, e, lat);
    check("word0_unmodified", rd, 32'h12345678);
    check("word0_err",        {31'd0, e}, 32'd0);

    // LATENCY=4: wait states and a request held across the busy window
    txn(1, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D, rd, e, lat);
    check("l4_st_lat", 32'(lat), 32'd4);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h8;
    n = 0;
    while (gnt[1] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("l4_gnt_timeout", {31'd0, gnt[1]}, 32'd1);
    @(negedge clk);
    flag = 1'b0;
    lat = 1;
    while (rvalid[1] !== 1'b1 && lat < 50) begin
      if (gnt[1] !== 1'b0) flag = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("l4_ld_lat",     32'(lat), 32'd4);
    check("l4_ld_rdata",   rdata[1], 32'hCAFEF00D);
    check("l4_gnt_busy",   {31'd0, flag}, 32'd0);
    check("l4_gnt_resp",   {31'd0, gnt[1]}, 32'd0);
    @(negedge clk);
    check("l4_gnt_idle",   {31'd0, gnt[1]}, 32'd1);
    check("l4_rvalid_low", {31'd0, rvalid[1]}, 32'd0);
    @(negedge clk);
    req[1] = 1'b0;
    check("l4_held_accepted", {31'd0, gnt[1]}, 32'd0);
    lat = 1;
    while (rvalid[1] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("l4_held_lat",   32'(lat), 32'd4);
    check("l4_held_rdata", rdata[1], 32'hCAFEF00D);

    // LATENCY=3: reset while a store is in flight
    txn(2, 1'b1, 4'hF, 32'h20, 32'h0, rd, e, lat);
    check("l3_st_lat", 32'(lat), 32'd3);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'h55AA55AA;
    n = 0;
    while (gnt[2] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("l3_gnt_timeout", {31'd0, gnt[2]}, 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    check("l3_busy", 32'(dbg[2]), 32'(BUSY));
    rst_n[2] = 1'b0;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid[2] !== 1'b0) flag = 1'b1;
    end
    check("l3_no_rvalid",     {31'd0, flag}, 32'd0);
    check("l3_state_in_rst",  32'(dbg[2]), 32'(IDLE));
    rst_n[2] = 1'b1;
    repeat (2) @(negedge clk);
    txn(2, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, lat);
    check("l3_discarded_store", rd, 32'h0);
    check("l3_ld_lat",          32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
